// File: rtl/tx_resp_ctrl_if.sv
// rtl/tx_resp_ctrl_if.sv - response-path bundle between ALU/RF, the response controller and UART TX
interface tx_resp_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
);
  logic [ALU_WIDTH-1:0]  ALU_OUT;
  logic                  OUT_Valid;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdData_Valid;
  logic                  Busy;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_Valid;
  logic                  clk_div_en;
  logic                  Queue_Full;
  logic                  Drop_Err;

  modport master (
    output ALU_OUT, OUT_Valid, RdData, RdData_Valid, Busy,
    input  TX_P_DATA, TX_D_Valid, clk_div_en, Queue_Full, Drop_Err
  );

  modport slave (
    input  ALU_OUT, OUT_Valid, RdData, RdData_Valid, Busy,
    output TX_P_DATA, TX_D_Valid, clk_div_en, Queue_Full, Drop_Err
  );
endinterface

// File: rtl/tx_resp_ctrl.sv
// rtl/tx_resp_ctrl.sv - queues ALU/RF results and streams them LSB byte first to the UART TX
module tx_resp_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ALU_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic           CLK,
  input logic           RST,
  tx_resp_ctrl_if.slave bus
);
  localparam int NB = ALU_WIDTH / DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t state, state_nx;

  // entry = {is_alu, payload}
  logic [ALU_WIDTH:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count, count_nx;
  logic                  full, empty, push_req, push, pop, drop;
  logic [ALU_WIDTH:0]    push_entry;

  logic [ALU_WIDTH-1:0]  shreg;
  logic [BW-1:0]         bcnt;
  logic [TW-1:0]         tmo;
  logic [DATA_WIDTH-1:0] tx_hold;
  logic                  clk_en_q, drop_q;

  // fullness is judged on the registered count, so a same-cycle pop never frees a slot
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push_req   = bus.OUT_Valid | bus.RdData_Valid;
  assign push       = push_req & ~full;
  assign pop        = (state == IDLE) & ~empty;
  assign drop       = (bus.OUT_Valid & bus.RdData_Valid) | (push_req & full);
  assign push_entry = bus.OUT_Valid ? {1'b1, bus.ALU_OUT} : {1'b0, ALU_WIDTH'(bus.RdData)};
  assign count_nx   = count + (AW+1)'(push) - (AW+1)'(pop);

  // queue pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
    end
  end

  // queue storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!empty) state_nx = LOAD;
      LOAD:    if (!bus.Busy) state_nx = SEND;
      SEND:    state_nx = WAIT_HI;
      WAIT_HI: begin
        if (bus.Busy)                           state_nx = WAIT_LO;
        else if (tmo == TW'(BUSY_TIMEOUT - 1))  state_nx = SEND;
      end
      WAIT_LO: if (!bus.Busy) state_nx = (bcnt != '0) ? SEND : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // byte datapath: load on pop, remember last byte sent, count the busy wait, shift between bytes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg   <= '0;
      bcnt    <= '0;
      tmo     <= '0;
      tx_hold <= '0;
    end else begin
      unique case (state)
        IDLE: if (!empty) begin
          shreg <= mem[rd_ptr][ALU_WIDTH-1:0];
          bcnt  <= mem[rd_ptr][ALU_WIDTH] ? BW'(NB - 1) : '0;
        end
        SEND: begin
          tmo     <= '0;
          tx_hold <= shreg[DATA_WIDTH-1:0];
        end
        WAIT_HI: if (!bus.Busy) tmo <= tmo + 1'b1;
        WAIT_LO: if (!bus.Busy && bcnt != '0) begin
          shreg <= shreg >> DATA_WIDTH;
          bcnt  <= bcnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // registered clock-enable and drop pulse so both are glitch-free
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_en_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      clk_en_q <= (state_nx != IDLE) | (count_nx != '0) | bus.Busy;
      drop_q   <= drop;
    end
  end

  // FSM outputs: the byte is only presented live in SEND, otherwise the last one is held
  always_comb begin
    bus.TX_D_Valid = (state == SEND);
    bus.TX_P_DATA  = (state == SEND) ? shreg[DATA_WIDTH-1:0] : tx_hold;
  end

  assign bus.clk_div_en = clk_en_q;
  assign bus.Queue_Full = full;
  assign bus.Drop_Err   = drop_q;
endmodule

// File: tb/tb_tx_resp_ctrl.sv
// tb/tb_tx_resp_ctrl.sv - self-checking bench for tx_resp_ctrl
module tb_tx_resp_ctrl;
  localparam int DW = 8;
  localparam int AWD = 16;
  localparam int NB = AWD / DW;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic force_busy = 1'b0;
  logic uart_busy = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_drop_cyc = -1;
  int resp_at = -1;
  int busy_left = 0;
  int uart_mode = 0;
  logic tmo_armed = 1'b0;
  int n_drops = 0;
  int strobe_cyc = 0;
  logic [DW-1:0] last_sent = '0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sent_bytes[$];
  int send_cycs[$];

  tx_resp_ctrl_if #(.DATA_WIDTH(DW), .ALU_WIDTH(AWD)) bus ();

  tx_resp_ctrl #(.DATA_WIDTH(DW), .ALU_WIDTH(AWD), .FIFO_DEPTH(4), .BUSY_TIMEOUT(15)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  assign bus.Busy = force_busy | uart_busy;

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic av, input logic [AWD-1:0] a, input logic rv,
                        input logic [DW-1:0] r, input logic full_drop);
    bus.OUT_Valid    = av;
    bus.ALU_OUT      = a;
    bus.RdData_Valid = rv;
    bus.RdData       = r;
    strobe_cyc = cyc;
    if (full_drop || (av && rv)) exp_drop_cyc = cyc + 1;
    if (!full_drop) begin
      if (av) for (int i = 0; i < NB; i++) exp_q.push_back(a[i*DW +: DW]);
      else if (rv) exp_q.push_back(r);
    end
    @(negedge CLK);
    bus.OUT_Valid    = 1'b0;
    bus.RdData_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 300 && !(exp_q.size() == 0 && !bus.Busy && !bus.clk_div_en)) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_reached", 32'(n < 300), 32'd1);
  endtask

  task automatic start_test();
    send_cycs.delete();
    sent_bytes.delete();
  endtask

  // per-cycle compare process plus a reactive UART model
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        chk("drop_err", 32'(bus.Drop_Err), 32'(cyc == exp_drop_cyc));
        if (bus.Drop_Err) n_drops++;
        if (bus.TX_D_Valid) begin
          chk("valid_while_busy", 32'(bus.Busy), 32'd0);
          send_cycs.push_back(cyc);
          sent_bytes.push_back(bus.TX_P_DATA);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_send: got %0h, required no send", bus.TX_P_DATA);
          end else begin
            chk("tx_byte", 32'(bus.TX_P_DATA), 32'(exp_q[0]));
          end
          last_sent = bus.TX_P_DATA;
          if (uart_mode == 0) resp_at = cyc + 1;
          else if (!tmo_armed) begin
            resp_at = cyc + 20;
            tmo_armed = 1'b1;
          end
        end else begin
          chk("tx_hold", 32'(bus.TX_P_DATA), 32'(last_sent));
        end
        if (cyc == resp_at) begin
          uart_busy = 1'b1;
          busy_left = 10;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          uart_mode = 0;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) uart_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    bus.OUT_Valid = 1'b0;
    bus.ALU_OUT = '0;
    bus.RdData_Valid = 1'b0;
    bus.RdData = '0;
    repeat (3) @(negedge CLK);
    chk("rst_tx_data", 32'(bus.TX_P_DATA), 32'd0);
    chk("rst_tx_valid", 32'(bus.TX_D_Valid), 32'd0);
    chk("rst_clk_en", 32'(bus.clk_div_en), 32'd0);
    chk("rst_full", 32'(bus.Queue_Full), 32'd0);
    chk("rst_drop", 32'(bus.Drop_Err), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // single ALU result
    start_test();
    strobe(1'b1, 16'hA55A, 1'b0, 8'h00, 1'b0);
    chk("t1_clk_en_active", 32'(bus.clk_div_en), 32'd1);
    wait_idle();
    chk("t1_sends", 32'(send_cycs.size()), 32'd2);
    chk("t1_b0", 32'(sent_bytes[0]), 32'h5A);
    chk("t1_b1", 32'(sent_bytes[1]), 32'hA5);
    chk("t1_latency", 32'(send_cycs[0] - strobe_cyc), 32'd3);
    chk("t1_byte_gap", 32'(send_cycs[1] - send_cycs[0]), 32'd12);
    chk("t1_clk_en_idle", 32'(bus.clk_div_en), 32'd0);

    // register-file read
    start_test();
    strobe(1'b0, 16'h0000, 1'b1, 8'h3C, 1'b0);
    wait_idle();
    chk("t2_sends", 32'(send_cycs.size()), 32'd1);
    chk("t2_b0", 32'(sent_bytes[0]), 32'h3C);
    chk("t2_latency", 32'(send_cycs[0] - strobe_cyc), 32'd3);

    // simultaneous strobes
    start_test();
    d0 = n_drops;
    strobe(1'b1, 16'h0F96, 1'b1, 8'h77, 1'b0);
    wait_idle();
    chk("t3_drops", 32'(n_drops - d0), 32'd1);
    chk("t3_sends", 32'(send_cycs.size()), 32'd2);
    chk("t3_b0", 32'(sent_bytes[0]), 32'h96);
    chk("t3_b1", 32'(sent_bytes[1]), 32'h0F);

    // overflow: first entry is taken into LOAD, four more fill the queue, the sixth is dropped
    start_test();
    d0 = n_drops;
    force_busy = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 1; i <= 4; i++) strobe(1'b0, 16'h0000, 1'b1, 8'(i), 1'b0);
    chk("t4_not_full", 32'(bus.Queue_Full), 32'd0);
    strobe(1'b0, 16'h0000, 1'b1, 8'h05, 1'b0);
    chk("t4_full", 32'(bus.Queue_Full), 32'd1);
    strobe(1'b0, 16'h0000, 1'b1, 8'h06, 1'b1);
    repeat (3) @(negedge CLK);
    chk("t4_hold_sends", 32'(send_cycs.size()), 32'd0);
    chk("t4_still_full", 32'(bus.Queue_Full), 32'd1);
    force_busy = 1'b0;
    wait_idle();
    chk("t4_drops", 32'(n_drops - d0), 32'd1);
    chk("t4_sends", 32'(send_cycs.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t4_order", 32'(sent_bytes[i]), 32'(i + 1));
    chk("t4_full_clear", 32'(bus.Queue_Full), 32'd0);

    // timeout retry
    start_test();
    uart_mode = 1;
    tmo_armed = 1'b0;
    strobe(1'b1, 16'hC3E1, 1'b0, 8'h00, 1'b0);
    wait_idle();
    chk("t5_sends", 32'(send_cycs.size()), 32'd3);
    chk("t5_retry_gap", 32'(send_cycs[1] - send_cycs[0]), 32'd16);
    chk("t5_b0", 32'(sent_bytes[0]), 32'hE1);
    chk("t5_b1", 32'(sent_bytes[1]), 32'hE1);
    chk("t5_b2", 32'(sent_bytes[2]), 32'hC3);

    // reset mid-frame
    start_test();
    strobe(1'b1, 16'h1234, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (n < 30 && !uart_busy) begin
      @(negedge CLK);
      n++;
    end
    chk("t6_busy_seen", 32'(n < 30), 32'd1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("t6_rst_tx_data", 32'(bus.TX_P_DATA), 32'd0);
    chk("t6_rst_tx_valid", 32'(bus.TX_D_Valid), 32'd0);
    chk("t6_rst_clk_en", 32'(bus.clk_div_en), 32'd0);
    chk("t6_rst_full", 32'(bus.Queue_Full), 32'd0);
    chk("t6_rst_drop", 32'(bus.Drop_Err), 32'd0);
    exp_q.delete();
    last_sent = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
    chk("t6_sends", 32'(send_cycs.size()), 32'd1);
    chk("t6_b0", 32'(sent_bytes[0]), 32'h34);
    chk("t6_clk_en_idle", 32'(bus.clk_div_en), 32'd0);
    chk("t6_full", 32'(bus.Queue_Full), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
